// File: rtl/sw_led_pkg.sv
// Shared definitions for the switch-driven LED pattern controller.
// Contents: LED width, mode codes, initial patterns, and helpers that map
// switch codes to modes and modes to their initial LED pattern.
package sw_led_pkg;

  localparam int unsigned LedWidth = 4;

  typedef enum logic [2:0] {
    ModeOff      = 3'd0,
    ModeAllOn    = 3'd1,
    ModeShiftL   = 3'd2,
    ModeShiftR   = 3'd3,
    ModeBlink    = 3'd4,
    ModeCount    = 3'd5,
    ModePingPong = 3'd6
  } mode_e;

  localparam logic [LedWidth-1:0] PatOff      = 4'b0000;
  localparam logic [LedWidth-1:0] PatAllOn    = 4'b1111;
  localparam logic [LedWidth-1:0] PatShiftL   = 4'b0001;
  localparam logic [LedWidth-1:0] PatShiftR   = 4'b1000;
  localparam logic [LedWidth-1:0] PatBlink    = 4'b0000;
  localparam logic [LedWidth-1:0] PatCount    = 4'b0000;
  localparam logic [LedWidth-1:0] PatPingPong = 4'b0001;

  // Ping-pong turn-around points.
  localparam logic [LedWidth-1:0] PatEndMsb = 4'b1000;
  localparam logic [LedWidth-1:0] PatEndLsb = 4'b0001;

  // Code 7 is a second OFF encoding, so it collapses onto ModeOff.
  function automatic mode_e decode_mode(input logic [2:0] code);
    mode_e m;
    case (code)
      3'd1:    m = ModeAllOn;
      3'd2:    m = ModeShiftL;
      3'd3:    m = ModeShiftR;
      3'd4:    m = ModeBlink;
      3'd5:    m = ModeCount;
      3'd6:    m = ModePingPong;
      default: m = ModeOff;
    endcase
    return m;
  endfunction

  function automatic logic [LedWidth-1:0] init_pattern(input mode_e m);
    logic [LedWidth-1:0] p;
    case (m)
      ModeAllOn:    p = PatAllOn;
      ModeShiftL:   p = PatShiftL;
      ModeShiftR:   p = PatShiftR;
      ModeBlink:    p = PatBlink;
      ModeCount:    p = PatCount;
      ModePingPong: p = PatPingPong;
      default:      p = PatOff;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a vector debouncer.
// The synchronized vector is accepted only after it has held the same value
// for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
// Ports:
//   clk_in - clock
//   rst    - asynchronous active-high reset
//   sw_raw - raw asynchronous switch inputs
//   sw_db  - debounced, synchronous switch vector
module sw_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db
);

  localparam int unsigned CntW =
      ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // cnt_d is the number of consecutive cycles sync2_q has held its value,
  // including the cycle being evaluated; saturates at DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q != prev_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (cnt_d >= CntMax) begin
      db_d = sync2_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: debounced switches select one of several LED
// patterns that advance once per tick.
// Ports:
//   clk_in - clock, all logic on rising edge
//   rst    - asynchronous active-high reset
//   sw     - raw switches; sw[2:0] select the mode, sw[3] pauses
//   led    - registered LED drive
//   tick   - one-cycle pulse on each pattern-advance instant
//   mode   - currently active mode code
module led_pattern_ctrl
  import sw_led_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 5_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [3:0]          sw,
  output logic [LedWidth-1:0] led,
  output logic                tick,
  output logic [2:0]          mode
);

  localparam int unsigned TickDiv  = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int unsigned TickCntW = ($clog2(TickDiv) < 1) ? 1 : $clog2(TickDiv);
  localparam logic [TickCntW-1:0] TickLast = TickCntW'(TickDiv - 1);

  logic [3:0]          sw_db;
  logic                pause;
  mode_e               mode_dec;
  logic                mode_change;
  logic                at_tc;
  logic                tick_int;

  mode_e               mode_q, mode_d;
  logic [LedWidth-1:0] led_q, led_d;
  logic                dir_left_q, dir_left_d;
  logic [TickCntW-1:0] tick_cnt_q, tick_cnt_d;

  sw_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk_in(clk_in),
    .rst   (rst),
    .sw_raw(sw),
    .sw_db (sw_db)
  );

  always_comb begin
    mode_dec    = decode_mode(sw_db[2:0]);
    pause       = sw_db[3];
    mode_change = (mode_dec != mode_q);
    at_tc       = (tick_cnt_q == TickLast);
    // A pending mode load swallows any tick in the same cycle.
    tick_int    = at_tc && !pause && !mode_change;

    tick_cnt_d = tick_cnt_q;
    if (mode_change || (at_tc && !pause)) begin
      tick_cnt_d = '0;
    end else if (!pause) begin
      tick_cnt_d = tick_cnt_q + TickCntW'(1);
    end

    mode_d     = mode_q;
    led_d      = led_q;
    dir_left_d = dir_left_q;
    if (mode_change) begin
      mode_d     = mode_dec;
      led_d      = init_pattern(mode_dec);
      dir_left_d = 1'b1;
    end else if (tick_int) begin
      unique case (mode_q)
        ModeOff, ModeAllOn: led_d = led_q;
        ModeShiftL:         led_d = {led_q[LedWidth-2:0], led_q[LedWidth-1]};
        ModeShiftR:         led_d = {led_q[0], led_q[LedWidth-1:1]};
        ModeBlink:          led_d = ~led_q;
        ModeCount:          led_d = led_q + LedWidth'(1);
        ModePingPong: begin
          if (dir_left_q) begin
            led_d = {led_q[LedWidth-2:0], 1'b0};
            if (led_d == PatEndMsb) dir_left_d = 1'b0;
          end else begin
            led_d = {1'b0, led_q[LedWidth-1:1]};
            if (led_d == PatEndLsb) dir_left_d = 1'b1;
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mode_q     <= ModeOff;
      led_q      <= PatOff;
      dir_left_q <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_left_q <= dir_left_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_int;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with CLK_HZ=10, TICK_HZ=1,
// DEBOUNCE_CYCLES=4. Inputs are driven and outputs sampled on the falling edge.
module tb_led_pattern_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] led;
  logic       tick;
  logic [2:0] mode;

  int errors = 0;
  int checks = 0;

  led_pattern_ctrl #(
    .CLK_HZ         (10),
    .TICK_HZ        (1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .sw    (sw),
    .led   (led),
    .tick  (tick),
    .mode  (mode)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance falling edges until tick is seen or the budget runs out.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (tick !== 1'b1 && n < budget);
  endtask

  task automatic wait_mode(input logic [2:0] exp, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (mode !== exp && n < budget);
  endtask

  // Wait for one tick, then check the pattern it produced one cycle later.
  task automatic step_tick(input string tag, input logic [3:0] exp_led, output int n);
    wait_tick(12, n);
    chk({tag, "_tick"}, 32'(tick), 32'd1);
    @(negedge clk_in);
    chk({tag, "_led"}, 32'(led), 32'(exp_led));
  endtask

  logic [3:0] shl_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] pp_exp  [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] cnt_exp [3] = '{4'b0001, 4'b0010, 4'b0011};

  initial begin
    int n;
    rst = 1'b1;
    sw  = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk_in);

    // Glitch: only 3 stable cycles, must be rejected
    sw = 4'b0010;
    repeat (3) @(negedge clk_in);
    sw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk("glitch_mode", 32'(mode), 32'd0);
    end

    // Held switch: mode/led within 2+4+2 cycles
    sw = 4'b0010;
    wait_mode(3'd2, 8, n);
    chk("shl_mode", 32'(mode), 32'd2);
    chk("shl_init", 32'(led), 32'b0001);

    // SHIFT_L: 5 ticks, 10 cycles apart
    for (int i = 0; i < 5; i++) begin
      step_tick("shl", shl_exp[i], n);
      if (i > 0) chk("shl_gap", 32'(n + 1), 32'd10);
    end

    // PINGPONG: 7 ticks
    sw = 4'b0110;
    wait_mode(3'd6, 8, n);
    chk("pp_mode", 32'(mode), 32'd6);
    chk("pp_init", 32'(led), 32'b0001);
    for (int i = 0; i < 7; i++) step_tick("pp", pp_exp[i], n);

    // Collision: counter is 0 here; 3 cycles on, the mode change lands at count 9
    repeat (3) @(negedge clk_in);
    sw = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      chk("col_notick", 32'(tick), 32'd0);
    end
    @(negedge clk_in);
    chk("col_mode", 32'(mode), 32'd4);
    chk("col_led", 32'(led), 32'b0000);
    step_tick("blink", 4'b1111, n);
    chk("col_gap", 32'(n + 1), 32'd10);

    // COUNT up to 0011, then PAUSE
    sw = 4'b0101;
    wait_mode(3'd5, 8, n);
    chk("cnt_mode", 32'(mode), 32'd5);
    chk("cnt_init", 32'(led), 32'b0000);
    for (int i = 0; i < 3; i++) step_tick("cnt", cnt_exp[i], n);
    sw = 4'b1101;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      chk("pause_tick", 32'(tick), 32'd0);
      chk("pause_led", 32'(led), 32'b0011);
    end
    // Counter froze at 6 once pause took effect; unpause takes 6 cycles,
    // then 3 more counts reach terminal count.
    sw = 4'b0101;
    step_tick("resume", 4'b0100, n);
    chk("resume_gap", 32'(n), 32'd9);
    step_tick("cnt5", 4'b0101, n);

    // Asynchronous reset mid-COUNT
    #2 rst = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk("post_rst_tick", 32'(tick), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 5_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1: pattern advance rate in Hz.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50_000: number of stable cycles required to accept a switch change.
REQ-004 SHALL have port clk_in, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sw, input, 4 bits: raw board switches, asynchronous to clk_in.
REQ-007 SHALL have port led, output, 4 bits: registered LED drive.
REQ-008 SHALL have port tick, output, 1 bit: one-cycle pulse on each pattern-advance instant.
REQ-009 SHALL have port mode, output, 3 bits: currently active mode code.

Function
REQ-010 SHALL pass each sw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL accept a synchronized sw vector as debounced only after it is unchanged for DEBOUNCE_CYCLES consecutive cycles; any change restarts the stability count.
REQ-012 SHALL decode debounced sw[2:0] as follows: 0 OFF, 1 ALL_ON, 2 SHIFT_L, 3 SHIFT_R, 4 BLINK, 5 COUNT, 6 PINGPONG, 7 OFF.
REQ-013 SHALL treat debounced sw[3]=1 as PAUSE: the tick counter holds, tick stays 0, and led holds its value.
REQ-014 SHALL run the tick counter from 0 to CLK_HZ/TICK_HZ-1 (integer division), assert tick in the terminal-count cycle, then wrap to 0.
REQ-015 SHALL size the counter width as $clog2(CLK_HZ/TICK_HZ), with a minimum of 1.
REQ-016 SHALL, in the cycle the decoded mode changes, clear the tick counter and suppress tick; in the next cycle, mode updates and led loads the initial pattern for the new mode.
REQ-017 SHALL use these initial patterns: OFF 0000, ALL_ON 1111, SHIFT_L 0001, SHIFT_R 1000, BLINK 0000, COUNT 0000, PINGPONG 0001 with direction set to left.
REQ-018 SHALL update led on tick with 1-cycle latency (led changes in the cycle after tick=1), as follows:
- OFF and ALL_ON: hold.
- SHIFT_L: rotate left.
- SHIFT_R: rotate right.
- BLINK: invert.
- COUNT: increment modulo 16 (1111 wraps to 0000).
- PINGPONG: move one position in the current direction; reverse direction on reaching 1000 or 0001 (sequence 0001, 0010, 0100, 1000, 0100, ...).
REQ-019 SHALL give a mode change priority over a tick arriving in the same cycle: the load wins and the tick is not emitted.
REQ-020 SHALL not reset pattern or counter on a PAUSE toggle; advancing resumes from the held count.

Reset
REQ-021 SHALL, while rst=1, hold led=0000, tick=0, mode=OFF, debounced sw=0000, synchronizer flops=0, all counters=0, and direction=left.
REQ-022 SHALL restart debounce and tick counting from 0 on the first clock after rst deasserts; reset asserted mid-pattern clears immediately without waiting for a clock.

Structure
REQ-023 SHALL place the mode code constants/enum, the 4-bit LED width, and the initial-pattern constants in shared package sw_led_pkg.
REQ-024 SHALL implement synchronizer plus debounce as sub-module sw_debounce (parameters WIDTH, DEBOUNCE_CYCLES), instantiated once for the 4-bit sw vector.
REQ-025 SHALL keep the tick generator, mode register, and pattern register in the top module.

Verification (CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4)
REQ-026 SHALL cover reset: assert rst mid-COUNT at led=0101 -> led=0000, mode=0, and tick=0 immediately; after release, no tick for 10 cycles.
REQ-027 SHALL cover debounce: sw=0010 stable 3 cycles, then glitch back -> mode stays OFF; sw=0010 held -> mode=2 and led=0001 within 2+4+2 cycles.
REQ-028 SHALL cover SHIFT_L: 5 ticks from 0001 -> 0010, 0100, 1000, 0001, 0010, with tick spaced exactly 10 cycles apart.
REQ-029 SHALL cover PINGPONG: 7 ticks -> 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-030 SHALL cover collision: a mode change to BLINK debounced in the terminal-count cycle -> no tick, led=0000, and next tick 10 cycles later gives 1111.
REQ-031 SHALL cover PAUSE: sw[3]=1 in COUNT at 0011 for 50 cycles -> led holds 0011 and tick stays 0; release -> counting continues to 0100 with no restart.
